// File: rtl/sub_seq_ctrl_if.sv
// Request/result bundle for the nibble-serial 16-bit subtractor.
// The master drives the operands and start; the slave returns the result and status flags.
interface sub_seq_ctrl_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic [15:0] D;
    logic        Bout;
    logic        Z;
    logic        V;
    logic        busy;
    logic        done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, Z, V, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, Z, V, busy, done
    );
endinterface

// File: rtl/sub_seq_ctrl.sv
// 16-bit subtractor built around a single 4-bit ripple slice.
// The slice is reused for four nibbles, LSB first, and produces D = A - B - Bin with flags.
module sub4_slice (
    output logic [3:0] D,
    output logic       Bout,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Bin
);
    logic [4:0] brw;

    always_comb begin
        brw    = '0;
        brw[0] = Bin;
        D      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            D[i]     = A[i] ^ B[i] ^ brw[i];
            brw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & brw[i]);
        end
        Bout = brw[4];
    end
endmodule

module sub_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    sub_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        br_q, br_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] d_q, d_d;
    logic        bout_q, bout_d;
    logic        z_q, z_d;
    logic        v_q, v_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  nib_a, nib_b, nib_d;
    logic        nib_bout;
    logic [15:0] d_full;

    // Select the current nibble and merge the slice result back into the full word.
    always_comb begin
        nib_a  = '0;
        nib_b  = '0;
        d_full = d_q;
        case (idx_q)
            2'd0: begin nib_a = a_q[3:0];   nib_b = b_q[3:0];   d_full[3:0]   = nib_d; end
            2'd1: begin nib_a = a_q[7:4];   nib_b = b_q[7:4];   d_full[7:4]   = nib_d; end
            2'd2: begin nib_a = a_q[11:8];  nib_b = b_q[11:8];  d_full[11:8]  = nib_d; end
            default: begin nib_a = a_q[15:12]; nib_b = b_q[15:12]; d_full[15:12] = nib_d; end
        endcase
    end

    sub4_slice u_slice (
        .D    (nib_d),
        .Bout (nib_bout),
        .A    (nib_a),
        .B    (nib_b),
        .Bin  (br_q)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        br_d    = br_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        bout_d  = bout_q;
        z_d     = z_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.Bin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                d_d  = d_full;
                br_d = nib_bout;
                if (idx_q == 2'd3) begin
                    // idx holds at 3 here and is cleared on the way back to IDLE.
                    bout_d  = nib_bout;
                    z_d     = (d_full == 16'h0000);
                    v_d     = (a_q[15] ^ b_q[15]) & (a_q[15] ^ d_full[15]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            br_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            z_q     <= 1'b1;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            z_q     <= z_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.Z    = z_q;
    assign bus.V    = v_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
